keyboard_ctrl_fsm: RTL and testbench

//  Registered decoder for playback commands typed as ASCII keys.

---
 rtl/keyboard_ctrl_fsm.sv | 145 ++++++++++++++
 tb/tb_keyboard_ctrl_fsm.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_ctrl_fsm.sv
// keyboard_ctrl_fsm
//   Registered decoder for playback commands typed as ASCII keys. It holds
//   the play/pause state and the forward/backward direction. It also
//   provides edge-qualified key acceptance, a restart pulse and a saturating
//   playback-speed divider. It sits between the PS/2 ASCII decoder and the
//   audio address counter / sample-rate clock divider.
//
// Ports
//   clk        in   1      system clock, rising-edge active
//   reset      in   1      asynchronous, active-high reset
//   letters    in   8      ASCII code of the last key
//   key_valid  in   1      high while letters carries a valid key
//   direction  out  2      {play, forward}
//   speed_div  out  DIV_W  current sample-rate divider
//   restart    out  1      one-cycle pulse: rewind address counter to track start
//   cmd_ack    out  1      one-cycle pulse: a recognised key was executed
//
// Build option
//   KEYBOARD_LOWERCASE_EN  when defined, lowercase e/d/f/b/u/s/r act like uppercase
//
// Parameter legality: DIV_MIN <= DIV_DEFAULT <= DIV_MAX < 2**DIV_W, DIV_STEP > 0.
module keyboard_ctrl_fsm #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 1000,
  parameter int DIV_MIN     = 100,
  parameter int DIV_MAX     = 4000,
  parameter int DIV_STEP    = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       letters,
  input  logic             key_valid,
  output logic [1:0]       direction,
  output logic [DIV_W-1:0] speed_div,
  output logic             restart,
  output logic             cmd_ack
);

  // State encoding is the direction output itself: {play, forward}.
  typedef enum logic [1:0] {
    PAUSE_BWD = 2'b00,
    PAUSE_FWD = 2'b01,
    PLAY_BWD  = 2'b10,
    PLAY_FWD  = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_PLAY,
    CMD_PAUSE,
    CMD_FWD,
    CMD_BWD,
    CMD_FASTER,
    CMD_SLOWER,
    CMD_RESTART
  } cmd_t;

  // Saturation limits are compared one bit wider than the divider so that
  // neither the limit nor the divider can wrap.
  localparam logic [DIV_W:0]   FAST_LIM     = (DIV_W+1)'(DIV_MIN + DIV_STEP);
  localparam bit               SLOW_STEP_OK = (DIV_STEP <= DIV_MAX);
  localparam logic [DIV_W:0]   SLOW_LIM     = (DIV_W+1)'(SLOW_STEP_OK ? DIV_MAX - DIV_STEP : 0);
  localparam logic [DIV_W-1:0] STEP_N       = DIV_W'(DIV_STEP);
  localparam logic [DIV_W-1:0] MIN_N        = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] MAX_N        = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] DEFAULT_N    = DIV_W'(DIV_DEFAULT);

  state_t           state_q;
  logic [DIV_W-1:0] speed_q;
  logic             key_valid_q;
  logic             restart_q;
  logic             cmd_ack_q;

  logic             accept;
  cmd_t             cmd;
  logic [DIV_W:0]   speed_wide;
  logic [DIV_W-1:0] faster_d;
  logic [DIV_W-1:0] slower_d;

  // Rising edge of key_valid only; key_valid_q resets high so a key held
  // through reset is ignored until it is released and pressed again.
  assign accept = key_valid & ~key_valid_q;

  always_comb begin
    cmd = CMD_NONE;
    case (letters)
      8'h45: cmd = CMD_PLAY;
      8'h44: cmd = CMD_PAUSE;
      8'h46: cmd = CMD_FWD;
      8'h42: cmd = CMD_BWD;
      8'h55: cmd = CMD_FASTER;
      8'h53: cmd = CMD_SLOWER;
      8'h52: cmd = CMD_RESTART;
`ifdef KEYBOARD_LOWERCASE_EN
      8'h65: cmd = CMD_PLAY;
      8'h64: cmd = CMD_PAUSE;
      8'h66: cmd = CMD_FWD;
      8'h62: cmd = CMD_BWD;
      8'h75: cmd = CMD_FASTER;
      8'h73: cmd = CMD_SLOWER;
      8'h72: cmd = CMD_RESTART;
`endif
      default: cmd = CMD_NONE;
    endcase
  end

  always_comb begin
    speed_wide = {1'b0, speed_q};
    faster_d   = (speed_wide >= FAST_LIM) ? speed_q - STEP_N : MIN_N;
    slower_d   = (SLOW_STEP_OK && (speed_wide <= SLOW_LIM)) ? speed_q + STEP_N : MAX_N;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PAUSE_FWD;
      speed_q     <= DEFAULT_N;
      key_valid_q <= 1'b1;
      restart_q   <= 1'b0;
      cmd_ack_q   <= 1'b0;
    end else begin
      key_valid_q <= key_valid;
      restart_q   <= 1'b0;
      cmd_ack_q   <= 1'b0;
      if (accept) begin
        cmd_ack_q <= (cmd != CMD_NONE);
        case (cmd)
          CMD_PLAY:    state_q <= state_q[0] ? PLAY_FWD  : PLAY_BWD;
          CMD_PAUSE:   state_q <= state_q[0] ? PAUSE_FWD : PAUSE_BWD;
          CMD_FWD:     state_q <= state_q[1] ? PLAY_FWD  : PAUSE_FWD;
          CMD_BWD:     state_q <= state_q[1] ? PLAY_BWD  : PAUSE_BWD;
          CMD_FASTER:  speed_q <= faster_d;
          CMD_SLOWER:  speed_q <= slower_d;
          CMD_RESTART: restart_q <= 1'b1;
          default:     ;
        endcase
      end
    end
  end

  assign direction = state_q;
  assign speed_div = speed_q;
  assign restart   = restart_q;
  assign cmd_ack   = cmd_ack_q;

endmodule

// File: tb/tb_keyboard_ctrl_fsm.sv
module tb_keyboard_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  letters;
  logic        key_valid;
  logic [1:0]  direction;
  logic [15:0] speed_div;
  logic        restart;
  logic        cmd_ack;

  always #5 clk = ~clk;

  keyboard_ctrl_fsm #(
    .DIV_W(16), .DIV_DEFAULT(1000), .DIV_MIN(100), .DIV_MAX(4000), .DIV_STEP(100)
  ) dut (
    .clk(clk), .reset(reset), .letters(letters), .key_valid(key_valid),
    .direction(direction), .speed_div(speed_div), .restart(restart), .cmd_ack(cmd_ack)
  );

  typedef struct packed {
    logic [1:0]  dir;
    logic [15:0] spd;
    logic        rst;
    logic        ack;
  } exp_t;

  exp_t        sb[$];
  logic [1:0]  m_dir;
  logic [15:0] m_spd;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: expected outputs after the accepting edge.
  task automatic press_start(input logic [7:0] k);
    exp_t       e;
    logic [7:0] u;
    u = k;
`ifdef KEYBOARD_LOWERCASE_EN
    if (k >= 8'h61 && k <= 8'h7a) u = k - 8'h20;
`endif
    e.rst = 1'b0;
    e.ack = 1'b1;
    case (u)
      8'h45: m_dir[1] = 1'b1;
      8'h44: m_dir[1] = 1'b0;
      8'h46: m_dir[0] = 1'b1;
      8'h42: m_dir[0] = 1'b0;
      8'h55: m_spd = (m_spd >= 16'd200)  ? m_spd - 16'd100 : 16'd100;
      8'h53: m_spd = (m_spd <= 16'd3900) ? m_spd + 16'd100 : 16'd4000;
      8'h52: e.rst = 1'b1;
      default: e.ack = 1'b0;
    endcase
    e.dir = m_dir;
    e.spd = m_spd;
    sb.push_back(e);
    @(negedge clk);
    letters   = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic release_key();
    @(negedge clk);
    key_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; key_valid = 1'b1; letters = 8'h45;
    m_dir = 2'b01; m_spd = 16'd1000;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({direction, speed_div, restart, cmd_ack} !== {2'b01, 16'd1000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got dir=%b spd=%0d rst=%b ack=%b, want dir=01 spd=1000 rst=0 ack=0",
               direction, speed_div, restart, cmd_ack);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({direction, cmd_ack} !== {2'b01, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_held_key: got dir=%b ack=%b, want dir=01 ack=0", direction, cmd_ack);
    end
    release_key();
  endtask

  task automatic test_transitions();
    logic [7:0] keys [4];
    logic [1:0] want [4];
    exp_t       e;
    keys = '{8'h45, 8'h42, 8'h44, 8'h46};
    want = '{2'b11, 2'b10, 2'b00, 2'b01};
    for (int i = 0; i < 4; i++) begin
      press_start(keys[i]);
      e = sb.pop_front();
      n_checks++;
      if ({direction, speed_div, restart, cmd_ack} !== e || direction !== want[i]) begin
        n_fail++;
        $display("FAIL transition_%0d: got dir=%b spd=%0d rst=%b ack=%b, want dir=%b spd=%0d rst=%b ack=%b",
                 i, direction, speed_div, restart, cmd_ack, want[i], e.spd, e.rst, e.ack);
      end
      release_key();
      n_checks++;
      if (cmd_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL transition_ack_end_%0d: got ack=%b, want 0", i, cmd_ack);
      end
    end
  endtask

  task automatic test_held_key();
    exp_t e;
    int   extra_acks;
    press_start(8'h55);
    e = sb.pop_front();
    n_checks++;
    if ({direction, speed_div, restart, cmd_ack} !== e) begin
      n_fail++;
      $display("FAIL held_first: got dir=%b spd=%0d ack=%b, want dir=%b spd=%0d ack=%b",
               direction, speed_div, cmd_ack, e.dir, e.spd, e.ack);
    end
    extra_acks = 0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      #1;
      if (cmd_ack !== 1'b0) extra_acks++;
    end
    n_checks++;
    if (speed_div !== 16'd900 || extra_acks != 0) begin
      n_fail++;
      $display("FAIL held_once: got spd=%0d extra_acks=%0d, want spd=900 extra_acks=0",
               speed_div, extra_acks);
    end
    release_key();
  endtask

  task automatic test_saturation();
    exp_t e;
    int   bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      press_start(8'h55);
      e = sb.pop_front();
      if ({direction, speed_div, restart, cmd_ack} !== e) bad++;
      release_key();
    end
    n_checks++;
    if (speed_div !== 16'd100 || bad != 0) begin
      n_fail++;
      $display("FAIL sat_min: got spd=%0d step_errors=%0d, want spd=100 step_errors=0", speed_div, bad);
    end
    bad = 0;
    for (int i = 0; i < 45; i++) begin
      press_start(8'h53);
      e = sb.pop_front();
      if ({direction, speed_div, restart, cmd_ack} !== e) bad++;
      release_key();
    end
    n_checks++;
    if (speed_div !== 16'd4000 || bad != 0) begin
      n_fail++;
      $display("FAIL sat_max: got spd=%0d step_errors=%0d, want spd=4000 step_errors=0", speed_div, bad);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (speed_div !== 16'd4000) begin
      n_fail++;
      $display("FAIL sat_hold: got spd=%0d, want 4000", speed_div);
    end
  endtask

  task automatic test_restart_unknown();
    exp_t e;
    press_start(8'h52);
    e = sb.pop_front();
    n_checks++;
    if ({direction, speed_div, restart, cmd_ack} !== e || restart !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_pulse: got dir=%b spd=%0d rst=%b ack=%b, want dir=%b spd=%0d rst=1 ack=1",
               direction, speed_div, restart, cmd_ack, e.dir, e.spd);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (restart !== 1'b0 || cmd_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_width: got rst=%b ack=%b, want rst=0 ack=0", restart, cmd_ack);
    end
    release_key();
    press_start(8'h58);
    e = sb.pop_front();
    n_checks++;
    if ({direction, speed_div, restart, cmd_ack} !== e || cmd_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL unknown_key: got dir=%b spd=%0d rst=%b ack=%b, want dir=%b spd=%0d rst=0 ack=0",
               direction, speed_div, restart, cmd_ack, e.dir, e.spd);
    end
    release_key();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    press_start(8'h45);
    e = sb.pop_front();
    n_checks++;
    if ({direction, speed_div, restart, cmd_ack} !== e) begin
      n_fail++;
      $display("FAIL b2b_first: got dir=%b ack=%b, want dir=%b ack=%b", direction, cmd_ack, e.dir, e.ack);
    end
    release_key();
    press_start(8'h44);
    e = sb.pop_front();
    n_checks++;
    if ({direction, speed_div, restart, cmd_ack} !== e || direction !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_second: got dir=%b ack=%b, want dir=01 ack=1", direction, cmd_ack);
    end
    release_key();
  endtask

  task automatic test_lowercase();
    exp_t e;
    press_start(8'h65);
    e = sb.pop_front();
    n_checks++;
`ifdef KEYBOARD_LOWERCASE_EN
    if ({direction, speed_div, restart, cmd_ack} !== e || direction !== 2'b11 || cmd_ack !== 1'b1) begin
`else
    if ({direction, speed_div, restart, cmd_ack} !== e || direction !== 2'b01 || cmd_ack !== 1'b0) begin
`endif
      n_fail++;
      $display("FAIL lowercase_e: got dir=%b ack=%b, want dir=%b ack=%b", direction, cmd_ack, e.dir, e.ack);
    end
    release_key();
  endtask

  task automatic test_reset_midop();
    exp_t e;
    press_start(8'h52);
    e = sb.pop_front();
    n_checks++;
    if ({direction, speed_div, restart, cmd_ack} !== e) begin
      n_fail++;
      $display("FAIL midop_pre: got rst=%b ack=%b, want rst=%b ack=%b", restart, cmd_ack, e.rst, e.ack);
    end
    reset = 1'b1;
    #1;
    m_dir = 2'b01; m_spd = 16'd1000;
    n_checks++;
    if ({direction, speed_div, restart, cmd_ack} !== {2'b01, 16'd1000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midop_reset: got dir=%b spd=%0d rst=%b ack=%b, want dir=01 spd=1000 rst=0 ack=0",
               direction, speed_div, restart, cmd_ack);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (cmd_ack !== 1'b0 || direction !== 2'b01) begin
      n_fail++;
      $display("FAIL midop_held_key: got dir=%b ack=%b, want dir=01 ack=0", direction, cmd_ack);
    end
    release_key();
  endtask

  initial begin
    test_reset();
    test_transitions();
    test_held_key();
    test_saturation();
    test_restart_unknown();
    test_back_to_back();
    test_lowercase();
    test_reset_midop();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
